cfi_log_queue: RTL
==================

CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of filter ports consumed.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries, power of two, >= NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port log_i  input  cfi_log_t[NR_COMMIT_PORTS]  per-port CFI log from filter stage.
REQ-006 SHALL have port cfi_i  input  NR_COMMIT_PORTS  per-port "log must be checked" qualifier.
REQ-007 SHALL have port stall_o  output  1  request to commit stage to hold retirement.
REQ-008 SHALL have port log_o  output  cfi_log_t  head-of-queue entry.
REQ-009 SHALL have port valid_o  output  1  log_o holds a valid entry.
REQ-010 SHALL have port ready_i  input  1  downstream checker accepts log_o.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port clear_i  input  1  clears overflow_o and drop_cnt_o.
REQ-013 SHALL have port overflow_o  output  1  sticky: at least one entry dropped.
REQ-014 SHALL have port drop_cnt_o  output  CFI_DROP_CNT_W  saturating count of dropped entries.

Function
REQ-015 SHALL treat port i as a push request iff cfi_i[i]=1; cfi_i[i]=0 ports are ignored.
REQ-016 SHALL enqueue requests in ascending port order (port 0 before port 1) into consecutive slots, compacting gaps.
REQ-017 SHALL compute free space as DEPTH minus registered count; a same-cycle pop does not add space.
REQ-018 SHALL accept the lowest-indexed min(free, requests) requests and drop the rest.
REQ-019 SHALL write accepted entries visible at log_o no earlier than the next cycle (1-cycle latency empty->valid_o).
REQ-020 SHALL assert valid_o iff count_o != 0; log_o = entry at read pointer.
REQ-021 SHALL pop one entry on a cycle with valid_o && ready_i; ready_i while empty has no effect.
REQ-022 SHALL hold log_o and valid_o stable while valid_o && !ready_i.
REQ-023 SHALL update count_o = count + accepted - popped every cycle; pointers wrap modulo DEPTH.
REQ-024 SHALL add the number of dropped entries to drop_cnt_o, saturating at all-ones, and set overflow_o on any drop.
REQ-025 SHALL give clear_i priority over same-cycle drops: both clear to 0, and that cycle's drops are not counted.

Reset
REQ-026 SHALL, with rst_i=1 at a clock edge, set pointers, count_o, overflow_o, drop_cnt_o to 0; valid_o=0, stall_o=0 the following cycle.
REQ-027 SHALL discard queue contents and ignore cfi_i/ready_i on any cycle rst_i=1, including mid-operation.
REQ-028 SHALL drive log_o as don't-care-free: all-zero when empty after reset.

Configuration
REQ-029 SHALL support macro CFI_QUEUE_STALL_EN.
REQ-030 SHALL, with CFI_QUEUE_STALL_EN defined, drive stall_o=1 combinationally whenever free < NR_COMMIT_PORTS; drops still counted if requests arrive anyway.
REQ-031 SHALL, without CFI_QUEUE_STALL_EN, tie stall_o to 0; overflow handled solely by drop (REQ-018, REQ-024).

Structure
REQ-032 SHALL place constant CFI_DROP_CNT_W (16) in cfi_pkg; SHALL reuse cfi_pkg::cfi_log_t unchanged.
REQ-033 SHALL implement compaction (REQ-016/018) in sub-module cfi_log_compact: inputs cfi_i and free, outputs per-port accept mask and slot offsets; storage and pointers remain in cfi_log_queue.

Verification
REQ-034 Both ports cfi_i=2'b11, pc 0x8000_0010/0x8000_0014, ready_i=0 -> next cycle count_o=2, log_o.addr_pc=0x8000_0010; after one pop 0x8000_0014.
REQ-035 cfi_i=2'b10 only -> single entry from port 1, count_o=1, no gap slot.
REQ-036 DEPTH=8, count=7, ready_i=0, cfi_i=2'b11 (no stall macro) -> port 0 accepted, count_o=8, drop_cnt_o=1, overflow_o=1; clear_i next cycle -> both 0.
REQ-037 Full queue, ready_i=1, cfi_i=2'b01 -> entry dropped (REQ-017), count_o=7 next cycle; 10 consecutive pointer wraps keep FIFO order.
REQ-038 CFI_QUEUE_STALL_EN defined, count=7 -> stall_o=1 same cycle; count=6 -> stall_o=0.
REQ-039 rst_i=1 with count=5 and valid_o=1 -> next cycle count_o=0, valid_o=0, drop_cnt_o=0; drop_cnt_o forced to 0xFFFE plus 2 drops -> 0xFFFF.

Source files
------------

// File: rtl/cfi_pkg.sv
// Shared CFI log types and constants for the CFI log queue.
// Used by cfi_log_queue and cfi_log_compact.
package cfi_pkg;

  localparam int unsigned CFI_DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    CfiJump   = 2'd0,
    CfiCall   = 2'd1,
    CfiRet    = 2'd2,
    CfiBranch = 2'd3
  } cfi_kind_e;

  typedef struct packed {
    cfi_kind_e   kind;
    logic [31:0] addr_pc;
    logic [31:0] addr_target;
  } cfi_log_t;

endpackage

// File: rtl/cfi_log_compact.sv
// Compaction of per-port push requests: the lowest-indexed requests that fit in the free
// space are accepted and each gets a slot offset counted over lower-indexed requests.
module cfi_log_compact
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic [NR_COMMIT_PORTS-1:0]                     cfi_i,
  input  logic [$clog2(DEPTH):0]                         free_i,
  output logic [NR_COMMIT_PORTS-1:0]                     accept_o,
  output logic [NR_COMMIT_PORTS-1:0][$clog2(DEPTH)-1:0]  offset_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] w_run;

  always_comb begin
    w_run    = '0;
    accept_o = '0;
    offset_o = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      // offset only matters for requesting ports; accepted ones are always below free_i
      offset_o[i] = PTR_W'(w_run);
      accept_o[i] = cfi_i[i] && (w_run < free_i);
      w_run       = w_run + CNT_W'(cfi_i[i]);
    end
  end

endmodule

// File: rtl/cfi_log_queue.sv
// Multi-port CFI log FIFO with drop accounting (sticky overflow, saturating drop count).
// Optional CFI_QUEUE_STALL_EN drives stall_o when free space is below NR_COMMIT_PORTS.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0] log_i,
  input  logic [NR_COMMIT_PORTS-1:0]    cfi_i,
  output logic                          stall_o,
  output cfi_log_t                      log_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(DEPTH):0]        count_o,
  input  logic                          clear_i,
  output logic                          overflow_o,
  output logic [CFI_DROP_CNT_W-1:0]     drop_cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CFI_DROP_CNT_W + 1;

  cfi_log_t                     r_mem [DEPTH];
  logic [PTR_W-1:0]             r_wptr, r_rptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_overflow;
  logic [CFI_DROP_CNT_W-1:0]    r_drop_cnt;

  logic [CNT_W-1:0]             w_free, w_n_req, w_n_acc, w_n_drop;
  logic [NR_COMMIT_PORTS-1:0]   w_accept;
  logic [NR_COMMIT_PORTS-1:0][PTR_W-1:0] w_offset, w_slot;
  logic                         w_pop;
  logic [SUM_W-1:0]             w_drop_sum;

  // Free space comes from the registered count only; a same-cycle pop frees nothing.
  assign w_free = CNT_W'(DEPTH) - r_count;

  cfi_log_compact #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .DEPTH           (DEPTH)
  ) u_compact (
    .cfi_i    (cfi_i),
    .free_i   (w_free),
    .accept_o (w_accept),
    .offset_o (w_offset)
  );

  always_comb begin
    w_n_req = '0;
    w_n_acc = '0;
    w_slot  = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_n_req   = w_n_req + CNT_W'(cfi_i[i]);
      w_n_acc   = w_n_acc + CNT_W'(w_accept[i]);
      w_slot[i] = r_wptr + w_offset[i];
    end
  end

  assign w_n_drop   = w_n_req - w_n_acc;
  assign w_drop_sum = {1'b0, r_drop_cnt} + SUM_W'(w_n_drop);
  assign valid_o    = (r_count != '0);
  assign w_pop      = valid_o & ready_i;
  assign log_o      = valid_o ? r_mem[r_rptr] : '0;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

`ifdef CFI_QUEUE_STALL_EN
  assign stall_o = (w_free < CNT_W'(NR_COMMIT_PORTS));
`else
  assign stall_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_accept[i]) r_mem[w_slot[i]] <= log_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_n_acc);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + w_n_acc - CNT_W'(w_pop);
      if (clear_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_n_drop != '0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[SUM_W-1] ? '1 : w_drop_sum[CFI_DROP_CNT_W-1:0];
      end
    end
  end

endmodule
